mem_io_responder: RTL

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

---
 rtl/mem_io_responder_if.sv | 26 ++
 rtl/mem_io_responder.sv | 124 ++++++++++++
 2 files changed

// File: rtl/mem_io_responder_if.sv
// CPU memory bus plus UART TX/RX handshakes shared by the responder and its user.
interface mem_io_responder_if;
  logic        rdy_in;
  logic [31:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_wr;
  logic [7:0]  cpu_rdata;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        program_stop;

  modport master (
    output rdy_in, cpu_addr, cpu_wdata, cpu_wr, tx_ready, rx_data, rx_valid,
    input  cpu_rdata, io_buffer_full, tx_data, tx_valid, rx_ready, program_stop
  );

  modport slave (
    input  rdy_in, cpu_addr, cpu_wdata, cpu_wr, tx_ready, rx_data, rx_valid,
    output cpu_rdata, io_buffer_full, tx_data, tx_valid, rx_ready, program_stop
  );
endinterface

// File: rtl/mem_io_responder.sv
// Byte RAM plus memory-mapped UART FIFOs, cycle counter and halt flag for a CPU.
// Define MEM_IO_RX_EN to build the UART RX FIFO readable at 0x30000.
module mem_io_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int TX_DEPTH   = 8,
  parameter int RX_DEPTH   = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  mem_io_responder_if.slave bus
);
  localparam int TX_AW       = $clog2(TX_DEPTH);
  localparam int TX_NEAR_INT = TX_DEPTH - 1;
  localparam logic [TX_AW:0] TX_FULL_CNT = TX_DEPTH[TX_AW:0];
  localparam logic [TX_AW:0] TX_NEAR_CNT = TX_NEAR_INT[TX_AW:0];

  logic [7:0]            ram    [0:(2**ADDR_WIDTH)-1];
  logic [7:0]            tx_mem [0:TX_DEPTH-1];
  logic [TX_AW:0]        tx_wr_ptr, tx_rd_ptr, tx_count;
  logic [31:0]           counter, snapshot;
  logic [7:0]            rdata_next, rx_head, tx_push_byte;
  logic [15:0]           io_off;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  is_io, io_wr, io_rd, tx_full, tx_empty, tx_push, tx_pop;

  assign is_io    = bus.cpu_addr[17:16] == 2'b11;
  assign io_off   = bus.cpu_addr[15:0];
  assign ram_addr = bus.cpu_addr[ADDR_WIDTH-1:0];
  assign io_wr    = bus.rdy_in && bus.cpu_wr && is_io;
  assign io_rd    = bus.rdy_in && !bus.cpu_wr && is_io;

  // The TX pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign tx_count     = tx_wr_ptr - tx_rd_ptr;
  assign tx_empty     = tx_count == '0;
  assign tx_full      = tx_count == TX_FULL_CNT;
  assign tx_pop       = !tx_empty && bus.tx_ready;
  assign tx_push_byte = (io_off == 16'h0004) ? 8'h00 : bus.cpu_wdata;
  assign tx_push      = io_wr && (!tx_full || tx_pop) &&
                        ((io_off == 16'h0000 && bus.cpu_wdata != 8'h00) || io_off == 16'h0004);

  assign bus.tx_valid       = !tx_empty;
  assign bus.tx_data        = tx_mem[tx_rd_ptr[TX_AW-1:0]];
  assign bus.io_buffer_full = tx_count >= TX_NEAR_CNT;

`ifdef MEM_IO_RX_EN
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL_CNT = RX_DEPTH[RX_AW:0];

  logic [7:0]     rx_mem [0:RX_DEPTH-1];
  logic [RX_AW:0] rx_wr_ptr, rx_rd_ptr, rx_count;
  logic           rx_full, rx_empty, rx_push, rx_pop;
  logic [13:0]    addr_unused;

  assign addr_unused  = bus.cpu_addr[31:18];
  assign rx_count     = rx_wr_ptr - rx_rd_ptr;
  assign rx_full      = rx_count == RX_FULL_CNT;
  assign rx_empty     = rx_count == '0;
  assign rx_push      = bus.rx_valid && !rx_full;
  assign rx_pop       = io_rd && io_off == 16'h0000 && !rx_empty;
  assign rx_head      = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr[RX_AW-1:0]];
  assign bus.rx_ready = !rx_full;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rx_push) rx_mem[rx_wr_ptr[RX_AW-1:0]] <= bus.rx_data;
  end
`else
  localparam int rx_depth_unused = RX_DEPTH;
  logic [22:0] rx_unused;

  assign rx_unused    = {bus.cpu_addr[31:18], bus.rx_data, bus.rx_valid};
  assign rx_head      = 8'h00;
  assign bus.rx_ready = 1'b0;
`endif

  always_comb begin
    rdata_next = 8'h00;
    if (!is_io) begin
      rdata_next = ram[ram_addr];
    end else begin
      case (io_off)
        16'h0000: rdata_next = rx_head;
        16'h0004: rdata_next = counter[7:0];
        16'h0005: rdata_next = snapshot[15:8];
        16'h0006: rdata_next = snapshot[23:16];
        16'h0007: rdata_next = snapshot[31:24];
        default:  rdata_next = 8'h00;
      endcase
    end
  end

  // Storage arrays carry no reset so RAM contents survive rst_in.
  always_ff @(posedge clk_in) begin
    if (bus.rdy_in && bus.cpu_wr && !is_io) ram[ram_addr] <= bus.cpu_wdata;
    if (tx_push) tx_mem[tx_wr_ptr[TX_AW-1:0]] <= tx_push_byte;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      counter          <= '0;
      snapshot         <= '0;
      bus.cpu_rdata    <= 8'h00;
      bus.program_stop <= 1'b0;
      tx_wr_ptr        <= '0;
      tx_rd_ptr        <= '0;
    end else begin
      counter <= counter + 32'd1;
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      if (bus.rdy_in && !bus.cpu_wr) bus.cpu_rdata <= rdata_next;
      if (io_rd && io_off == 16'h0004) snapshot <= counter;
      if (io_wr && io_off == 16'h0004) bus.program_stop <= 1'b1;
    end
  end
endmodule
